// File: rtl/fm_discriminator_if.sv
// I/Q sample input and frequency output bundle for fm_discriminator.
// The slave modport is the demodulator's view; master is the source/sink side.
interface fm_discriminator_if #(
    parameter int IQ_W  = 12,
    parameter int OUT_W = 12
);
    logic                    in_valid;
    logic signed [IQ_W-1:0]  i_in;
    logic signed [IQ_W-1:0]  q_in;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, i_in, q_in,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, i_in, q_in,
        output out_valid, out_data
    );
endinterface

// File: rtl/fm_discriminator.sv
// FM demodulator: pipelined CORDIC phase, wrapping differentiator, integrate-and-dump by DEC.
// Define FM_DEEMPH_EN to add a one-pole de-emphasis IIR on the dumped samples (+1 cycle).
module fm_discriminator #(
    parameter int IQ_W   = 12,
    parameter int PH_W   = 16,
    parameter int STAGES = 14,
    parameter int DEC    = 1,
    parameter int OUT_W  = 12
) (
    input  logic              clk,
    input  logic              areset,
    fm_discriminator_if.slave bus
);
    localparam int W       = IQ_W + 2;
    localparam int DEC_LOG = $clog2(DEC);
    localparam int ACC_W   = PH_W + DEC_LOG;
    localparam int CNT_W   = (DEC_LOG > 0) ? DEC_LOG : 1;

    function automatic logic [PH_W-1:0] atan_lsb(input int k);
        real t, term, sum, scale;
        t = 1.0;
        for (int n = 0; n < k; n++) t = t / 2.0;
        if (k == 0) begin
            sum = 0.78539816339744830962;
        end else begin
            sum  = 0.0;
            term = t;
            for (int n = 0; n < 40; n++) begin
                sum  = sum + ((n % 2 == 0) ? 1.0 : -1.0) * term / real'(2 * n + 1);
                term = term * t * t;
            end
        end
        scale = 1.0;
        for (int n = 0; n < PH_W; n++) scale = scale * 2.0;
        return PH_W'($rtoi(sum * scale / 6.283185307179586477 + 0.5));
    endfunction

    function automatic logic [STAGES*PH_W-1:0] atan_table();
        logic [STAGES*PH_W-1:0] tab;
        tab = '0;
        for (int k = 0; k < STAGES; k++) tab[k*PH_W +: PH_W] = atan_lsb(k);
        return tab;
    endfunction

    localparam logic [STAGES*PH_W-1:0] ATAN_TAB = atan_table();

    logic signed [W-1:0]    x_r [0:STAGES];
    logic signed [W-1:0]    y_r [0:STAGES];
    logic        [PH_W-1:0] z_r [0:STAGES];
    logic        [STAGES:0] v_r;
    logic        [STAGES:0] zf_r;
    logic signed [W-1:0]    i_ext;
    logic signed [W-1:0]    q_ext;

    assign i_ext = W'(bus.i_in);
    assign q_ext = W'(bus.q_in);

    // Pre-rotation folds the left half-plane onto the right, then each stage drives y to zero.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            v_r  <= '0;
            zf_r <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                x_r[k] <= '0;
                y_r[k] <= '0;
                z_r[k] <= '0;
            end
        end else begin
            v_r[0] <= bus.in_valid;
            if (bus.in_valid) begin
                zf_r[0] <= (bus.i_in == '0) && (bus.q_in == '0);
                if (bus.i_in[IQ_W-1]) begin
                    x_r[0] <= -i_ext;
                    y_r[0] <= -q_ext;
                    z_r[0] <= {1'b1, {(PH_W-1){1'b0}}};
                end else begin
                    x_r[0] <= i_ext;
                    y_r[0] <= q_ext;
                    z_r[0] <= '0;
                end
            end
            for (int k = 0; k < STAGES; k++) begin
                v_r[k+1]  <= v_r[k];
                zf_r[k+1] <= zf_r[k];
                if (!y_r[k][W-1]) begin
                    x_r[k+1] <= x_r[k] + (y_r[k] >>> k);
                    y_r[k+1] <= y_r[k] - (x_r[k] >>> k);
                    z_r[k+1] <= z_r[k] + ATAN_TAB[k*PH_W +: PH_W];
                end else begin
                    x_r[k+1] <= x_r[k] - (y_r[k] >>> k);
                    y_r[k+1] <= y_r[k] + (x_r[k] >>> k);
                    z_r[k+1] <= z_r[k] - ATAN_TAB[k*PH_W +: PH_W];
                end
            end
        end
    end

    logic            ph_v;
    logic [PH_W-1:0] ph;
    logic            first;
    logic            d_v;
    logic [PH_W-1:0] ph_prev;
    logic [PH_W-1:0] d;

    // Modular subtraction makes the difference land in [-pi, pi) without an unwrap stage.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ph_v    <= 1'b0;
            ph      <= '0;
            first   <= 1'b1;
            d_v     <= 1'b0;
            ph_prev <= '0;
            d       <= '0;
        end else begin
            ph_v <= v_r[STAGES];
            if (v_r[STAGES]) ph <= zf_r[STAGES] ? '0 : z_r[STAGES];
            d_v <= ph_v;
            if (ph_v) begin
                d       <= first ? '0 : ph - ph_prev;
                ph_prev <= ph;
                first   <= 1'b0;
            end
        end
    end

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] d_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic        [CNT_W-1:0] cnt;
    logic                    dump_v;
    logic signed [OUT_W-1:0] raw;

    assign d_ext    = ACC_W'($signed(d));
    assign acc_next = acc + d_ext;

    // The DEC-th difference closes the block; the top OUT_W bits give the average.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            acc    <= '0;
            cnt    <= '0;
            dump_v <= 1'b0;
            raw    <= '0;
        end else begin
            dump_v <= 1'b0;
            if (d_v) begin
                if (cnt == CNT_W'(DEC - 1)) begin
                    acc    <= '0;
                    cnt    <= '0;
                    dump_v <= 1'b1;
                    raw    <= acc_next[ACC_W-1 -: OUT_W];
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef FM_DEEMPH_EN
    logic signed [OUT_W+3:0] y_de;
    logic signed [OUT_W+4:0] de_diff;
    logic                    de_v;

    assign de_diff = (OUT_W+5)'($signed({raw, 4'b0000})) - (OUT_W+5)'(y_de);

    // Four extra fraction bits keep the 1/16 leak from stalling on small steps.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            y_de <= '0;
            de_v <= 1'b0;
        end else begin
            de_v <= dump_v;
            if (dump_v) y_de <= y_de + (OUT_W+4)'(de_diff >>> 4);
        end
    end

    assign bus.out_valid = de_v;
    assign bus.out_data  = y_de[OUT_W+3 -: OUT_W];
`else
    assign bus.out_valid = dump_v;
    assign bus.out_data  = raw;
`endif
endmodule
